// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA streaming controller and the
// modular-exponentiation core it drives.
package rsa_pkg;

  localparam int DEF_BASE_WIDTH = 6;
  localparam int DEF_EXPO_WIDTH = 6;
  localparam int DEF_N_WIDTH    = 6;

  // The core stretches its internal reset for two cycles after start.
  localparam int GUARD_CYCLES = 2;
  localparam int WDOG_MARGIN  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GUARD,
    WAIT,
    PUSH
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rsa_out_reg.sv
// One-entry valid/ready holding register carrying a data word and an error flag.
// Usable as a skid-free output stage by any stream block.
module rsa_out_reg
  import rsa_pkg::*;
#(
  parameter int data_width = DEF_N_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [data_width-1:0] load_data,
  input  logic                  load_err,
  output logic                  can_load,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_err
);

  // A new word may enter when the slot is empty or is being drained this cycle.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (load && can_load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_err   <= load_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa_stream_ctrl.sv
// Streams plaintext symbols through an external modular-exponentiation core,
// one ciphertext per symbol, with range checking, output buffering and a watchdog.
module rsa_stream_ctrl
  import rsa_pkg::*;
#(
  parameter int base_width = DEF_BASE_WIDTH,
  parameter int expo_width = DEF_EXPO_WIDTH,
  parameter int N_width    = DEF_N_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_load,
  input  logic [expo_width-1:0] key_expo,
  input  logic [N_width-1:0]    key_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [base_width-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_width-1:0]    out_data,
  output logic                  out_err,
  output logic                  core_start,
  output logic [base_width-1:0] core_base,
  output logic [expo_width-1:0] core_expo,
  output logic [N_width-1:0]    core_N,
  input  logic [N_width-1:0]    core_result,
  input  logic                  core_valid,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int CMP_W  = max_int(base_width, N_width);
  localparam int WDOG_W = expo_width + 2;
  localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_W'((1 << expo_width) + WDOG_MARGIN - 1);
  localparam logic [WDOG_W-1:0] GUARD_LAST = WDOG_W'(GUARD_CYCLES - 1);

  state_t                state;
  logic                  key_valid;
  logic [expo_width-1:0] key_expo_reg;
  logic [N_width-1:0]    key_n_reg;
  logic [base_width-1:0] sym_reg;
  logic [N_width-1:0]    pend_data;
  logic                  pend_err;
  logic [WDOG_W-1:0]     wdog_cnt;
  logic                  accept;
  logic                  in_range;
  logic                  can_load;
  logic                  push_load;

  assign in_ready   = (state == IDLE) && key_valid && !key_load;
  assign accept     = in_valid && in_ready;
  assign in_range   = (CMP_W'(in_data) < CMP_W'(key_n_reg)) && (key_n_reg != '0);
  assign push_load  = (state == PUSH) && can_load;
  assign core_start = rst || (state == LAUNCH);
  assign busy       = (state != IDLE);
  assign core_base  = sym_reg;
  assign core_expo  = key_expo_reg;
  assign core_N     = key_n_reg;

  // The watchdog counter doubles as the guard-window timer since both start at LAUNCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      key_valid    <= 1'b0;
      key_expo_reg <= '0;
      key_n_reg    <= '0;
      sym_reg      <= '0;
      pend_data    <= '0;
      pend_err     <= 1'b0;
      wdog_cnt     <= '0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            key_valid    <= 1'b1;
            key_expo_reg <= key_expo;
            key_n_reg    <= key_N;
          end else if (accept) begin
            if (in_range) begin
              sym_reg <= in_data;
              state   <= LAUNCH;
            end else begin
              pend_data <= '0;
              pend_err  <= 1'b1;
              state     <= PUSH;
            end
          end
        end
        LAUNCH: begin
          wdog_cnt <= '0;
          state    <= GUARD;
        end
        GUARD, WAIT: begin
          if (state == WAIT && core_valid) begin
            pend_data <= core_result;
            pend_err  <= 1'b0;
            state     <= PUSH;
          end else if (wdog_cnt == WDOG_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (state == GUARD && wdog_cnt == GUARD_LAST) begin
              state <= WAIT;
            end
          end
        end
        PUSH: begin
          if (can_load) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rsa_out_reg #(
    .data_width(N_width)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (push_load),
    .load_data(pend_data),
    .load_err (pend_err),
    .can_load (can_load),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

endmodule

// File: doc/rsa_stream_ctrl.md
# rsa_stream_ctrl

- Streams plaintext symbols into the modular-exponentiation core (`RSA_top`) and returns one ciphertext symbol per input symbol.
- Input and output use valid/ready handshakes.
- Holds the key (expo, N) and sequences the core's start/valid protocol.
- Range-checks each symbol, buffers results against output back-pressure, and detects a hung core with a watchdog.

## Interface
Parameters:
- base_width, 6, symbol width (core base width)
- expo_width, 6, exponent width
- N_width, 6, modulus and result width

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- key_load  in  1  latch key_expo/key_N; honoured only in IDLE
- key_expo  in  expo_width  exponent to latch
- key_N  in  N_width  modulus to latch
- in_valid  in  1  plaintext symbol valid
- in_ready  out  1  symbol accepted when in_valid&&in_ready
- in_data  in  base_width  plaintext symbol
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer ready
- out_data  out  N_width  ciphertext
- out_err  out  1  symbol was out of range; out_data is 0
- core_start  out  1  to core start
- core_base  out  base_width  to core base (latched symbol)
- core_expo  out  expo_width  to core expo (latched key)
- core_N  out  N_width  to core N (latched key)
- core_result  in  N_width  from core result
- core_valid  in  1  from core valid
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky; core never signalled valid

## Operation
- key_valid register:
  - Set by key_load in IDLE, which latches key_expo/key_N.
  - key_load outside IDLE is ignored.
  - Cleared only by rst.
- in_ready = (state==IDLE) && key_valid && !key_load. key_load wins over a same-cycle symbol.
- FSM states: IDLE, LAUNCH, GUARD, WAIT, PUSH.
  - IDLE, symbol accepted with in_data < key_N and key_N != 0: latch symbol into sym_reg, go to LAUNCH.
  - IDLE, symbol accepted otherwise: pend_data=0, pend_err=1, go to PUSH. The core is not started.
  - LAUNCH: core_start=1 for exactly one cycle, then GUARD.
  - GUARD: 2 cycles, core_valid ignored. This covers the core's registered-start reset extension. Then WAIT.
  - WAIT, core_valid=1: pend_data=core_result, pend_err=0, go to PUSH.
  - PUSH: when the output register is empty or draining this cycle, move pend into it and go to IDLE; otherwise stay.
- core_start = rst || state==LAUNCH, so the core is held in reset whenever this block is.
- Output register is a one-entry valid/ready holding stage.
  - out_data/out_err are stable while out_valid && !out_ready.
  - Symbol n+1 may be accepted and computed while symbol n waits in the output register.
- Watchdog:
  - Counts cycles spent in GUARD+WAIT; cleared in LAUNCH.
  - Reaching 2^expo_width+3 sets err_timeout, drops the symbol (nothing output), and returns to IDLE.
- Widths: comparisons are unsigned. in_data is zero-extended to max(base_width, N_width) before the range check.

## Timing
- Reset values:
  - state=IDLE, key_valid=0, in_ready=0
  - out_valid=0, out_data=0, out_err=0
  - busy=0, err_timeout=0, core_start=1
- rst mid-operation aborts at once. The in-flight symbol and the buffered output are discarded, and the key must be reloaded.
- Accept at edge t:
  - LAUNCH at t+1.
  - GUARD at t+2..t+3.
  - WAIT from t+4.
- First WAIT cycle c with core_valid=1:
  - PUSH at c+1.
  - out_valid=1 at c+2 if the output register is free.
  - in_ready=1 again at c+2.
- Out-of-range symbol: out_valid 2 cycles after accept (PUSH, then output), if free.
- out_valid && out_ready at the same edge that PUSH loads: the new value replaces the old with no bubble.
- Core result is read only in WAIT. core_valid seen in IDLE/LAUNCH/GUARD is ignored.

## Structure
- Package rsa_pkg holds:
  - FSM state enum
  - GUARD_CYCLES=2
  - WDOG_MARGIN=3
  - default width constants shared with RSA_top
- Sub-module rsa_out_reg: the one-entry valid/ready holding register (data + err). It is reusable by other stream stages.
- The core is instantiated by the parent; this block only drives and receives its ports.

## Test plan
- Load key N=33, expo=7; send 2 then 5, out_ready=1 -> outputs 29 then 14, out_err=0, each 2 cycles after its core_valid.
- Key N=33; send 40 -> out_data=0, out_err=1, core_start never pulses, out_valid 2 cycles after accept.
- expo=0: N=1, symbol 0 -> 0; N=33, symbol 5 -> 1. Checks that core_valid during GUARD is ignored.
- out_ready=0; send 2 and 5 (N=33, e=7) -> 29 held stable; FSM waits in PUSH with in_ready=0. Raise out_ready -> 29, then 14 with no bubble.
- Core model never asserts core_valid -> err_timeout=1 after 67 GUARD+WAIT cycles, state IDLE, no output. Next symbol still processed, err_timeout stays 1.
- rst asserted mid-WAIT -> next cycle out_valid=0, in_ready=0 (key cleared), core_start=1 during rst. key_load during WAIT is ignored and the old key is used.
